// File: rtl/mc_riscv_ctrl_gen.sv
// mc_riscv_ctrl_gen -- multi-cycle RV32I control FSM.
//   Reads the IR fields (opc/f3/f7) and ALU flags from the datapath and produces
//   every datapath enable and mux select. Outputs are Moore (state only), except
//   pc_w in BRANCH (taken flag) and the FETCH/MEM_RD/MEM_WR ready gating.
// Parameters
//   MEM_WAIT    : 1 = memory states hold until mem_ready, 0 = single-cycle memory
//   HAS_UBRANCH : 1 = bltu/bgeu legal, 0 = they trap
//   HAS_SHIFT   : 1 = sll/srl/sra(+i) legal, 0 = they trap
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   opc, f3, f7         : IR[6:0], IR[14:12], IR[31:25]
//   zero, sign, ltu     : ALU flags (==0, signed <, unsigned <)
//   mem_ready           : memory completes the access this cycle
//   pc_w .. adr_src     : write enables / address mux (0 PC, 1 ALUOut)
//   imm_src             : 0 I, 1 S, 2 B, 3 J, 4 U
//   alu_ctl             : 0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra
//   alu_src_a/alu_src_b : A 0 PC,1 OldPC,2 rs1; B 0 rs2,1 imm,2 const 4
//   result_src          : 0 ALUOut, 1 MemData, 2 ALUResult, 3 ImmExt
//   illegal, state      : trap flag, current state (debug)
module mc_riscv_ctrl_gen #(
    parameter bit MEM_WAIT    = 1'b1,
    parameter bit HAS_UBRANCH = 1'b1,
    parameter bit HAS_SHIFT   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       sign,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_w,
    output logic       oldpc_w,
    output logic       ir_w,
    output logic       reg_w,
    output logic       mem_w,
    output logic       mem_r,
    output logic       adr_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_ctl,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I = 4'd3,
        ALU_WB  = 4'd4,  MEM_ADR = 4'd5, MEM_RD = 4'd6,  MEM_WB = 4'd7,
        MEM_WR  = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, JALR   = 4'd11,
        LUI     = 4'd12, AUIPC  = 4'd13, TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_R = 7'd51, OP_I = 7'd19, OP_LD = 7'd3, OP_ST = 7'd35,
                           OP_BR = 7'd99, OP_JAL = 7'd111, OP_JALR = 7'd103,
                           OP_LUI = 7'd55, OP_AUIPC = 7'd23;
    localparam logic [6:0] F7_ALT = 7'h20;

    state_t cur, nxt;
    logic   rdy;

    assign rdy = mem_ready | ~MEM_WAIT;

    function automatic logic r_legal(input logic [2:0] fn3, input logic [6:0] fn7);
        logic shift;
        shift = (fn3 == 3'd1) || (fn3 == 3'd5);
        if (fn7 == 7'd0)
            r_legal = !shift || HAS_SHIFT;
        else if (fn7 == F7_ALT)
            r_legal = (fn3 == 3'd0) || ((fn3 == 3'd5) && HAS_SHIFT);
        else
            r_legal = 1'b0;
    endfunction

    function automatic logic i_legal(input logic [2:0] fn3, input logic [6:0] fn7);
        case (fn3)
            3'd1:    i_legal = HAS_SHIFT && (fn7 == 7'd0);
            3'd5:    i_legal = HAS_SHIFT && ((fn7 == 7'd0) || (fn7 == F7_ALT));
            default: i_legal = 1'b1;
        endcase
    endfunction

    function automatic logic br_legal(input logic [2:0] fn3);
        case (fn3)
            3'd0, 3'd1, 3'd4, 3'd5: br_legal = 1'b1;
            3'd6, 3'd7:             br_legal = HAS_UBRANCH;
            default:                br_legal = 1'b0;
        endcase
    endfunction

    // Shared R/I decode; only f3=0 differs (R uses f7 to pick sub, I is always addi).
    function automatic logic [3:0] alu_op(input logic is_r, input logic [2:0] fn3,
                                          input logic [6:0] fn7);
        case (fn3)
            3'd0:    alu_op = (is_r && fn7 == F7_ALT) ? 4'd1 : 4'd0;
            3'd1:    alu_op = 4'd7;
            3'd2:    alu_op = 4'd5;
            3'd3:    alu_op = 4'd6;
            3'd4:    alu_op = 4'd4;
            3'd5:    alu_op = (fn7 == F7_ALT) ? 4'd9 : 4'd8;
            3'd6:    alu_op = 4'd3;
            default: alu_op = 4'd2;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt        = cur;
        pc_w       = 1'b0;
        oldpc_w    = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        adr_src    = 1'b0;
        imm_src    = 3'd0;
        alu_ctl    = 4'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        result_src = 2'd0;
        illegal    = 1'b0;
        state      = cur;

        case (cur)
            FETCH: begin
                mem_r      = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                // Enables only fire on the completing cycle so a held fetch is idempotent.
                ir_w    = rdy;
                pc_w    = rdy;
                oldpc_w = rdy;
                if (rdy) nxt = DECODE;
            end
            DECODE: begin
                // Precompute branch/jal target into ALUOut while decoding.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = (opc == OP_BR) ? 3'd2 : 3'd3;
                case (opc)
                    OP_R:      nxt = r_legal(f3, f7) ? EXEC_R : TRAP;
                    OP_I:      nxt = i_legal(f3, f7) ? EXEC_I : TRAP;
                    OP_LD,
                    OP_ST:     nxt = MEM_ADR;
                    OP_BR:     nxt = br_legal(f3) ? BRANCH : TRAP;
                    OP_JAL:    nxt = JUMP;
                    OP_JALR:   nxt = (f3 == 3'd0) ? JALR : TRAP;
                    OP_LUI:    nxt = LUI;
                    OP_AUIPC:  nxt = AUIPC;
                    default:   nxt = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 2'd2;
                alu_ctl   = alu_op(1'b1, f3, f7);
                nxt       = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_ctl   = alu_op(1'b0, f3, f7);
                nxt       = ALU_WB;
            end
            ALU_WB: begin
                reg_w = 1'b1;
                nxt   = FETCH;
            end
            MEM_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (opc == OP_ST) ? 3'd1 : 3'd0;
                nxt       = (opc == OP_ST) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                adr_src = 1'b1;
                mem_r   = 1'b1;
                if (rdy) nxt = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'd1;
                reg_w      = 1'b1;
                nxt        = FETCH;
            end
            MEM_WR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (rdy) nxt = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'd2;
                alu_ctl   = 4'd1;
                case (f3)
                    3'd0:    pc_w = zero;
                    3'd1:    pc_w = ~zero;
                    3'd4:    pc_w = sign;
                    3'd5:    pc_w = ~sign;
                    3'd6:    pc_w = ltu;
                    3'd7:    pc_w = ~ltu;
                    default: pc_w = 1'b0;
                endcase
                nxt = FETCH;
            end
            JALR: begin
                // rs1+imm lands in ALUOut; JUMP then loads it into PC unmodified.
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                nxt       = JUMP;
            end
            JUMP: begin
                pc_w      = 1'b1;
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                nxt       = ALU_WB;
            end
            LUI: begin
                imm_src    = 3'd4;
                result_src = 2'd3;
                reg_w      = 1'b1;
                nxt        = FETCH;
            end
            AUIPC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = 3'd4;
                nxt       = ALU_WB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: nxt = FETCH;
        endcase

        // Reset masks everything, including the debug state, for its full duration.
        if (rst) begin
            pc_w       = 1'b0;
            oldpc_w    = 1'b0;
            ir_w       = 1'b0;
            reg_w      = 1'b0;
            mem_w      = 1'b0;
            mem_r      = 1'b0;
            adr_src    = 1'b0;
            imm_src    = 3'd0;
            alu_ctl    = 4'd0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            result_src = 2'd0;
            illegal    = 1'b0;
            state      = 4'd0;
        end
    end

endmodule
